mem_stage_sram_ctrl: RTL

//  MEM-stage memory controller, directly downstream of the EXE pipeline register. Takes
//  MEM_R_En/MEM_W_En, the ALU-computed address and store value, and performs a 32-bit

---
 rtl/mem_stage_sram_ctrl_pkg.sv | 15 +
 rtl/mem_stage_sram_ctrl_if.sv | 23 ++
 rtl/mem_stage_sram_ctrl_sram_wait_counter.sv | 33 +++
 rtl/mem_stage_sram_ctrl.sv | 122 ++++++++++++
 4 files changed

// File: rtl/mem_stage_sram_ctrl_pkg.sv
// rtl/mem_stage_sram_ctrl_pkg.sv - shared MEM-stage SRAM controller types and defaults
package mem_stage_sram_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_DONE = 2'd3
   } mem_state_t;

   localparam logic [31:0] BASE_ADDR_DEFAULT   = 32'd1024;
   localparam int          WAIT_CYCLES_DEFAULT = 1;
   localparam int          SRAM_AW_DEFAULT     = 18;

endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// rtl/mem_stage_sram_ctrl_if.sv - external 16-bit SRAM pad bus
interface mem_stage_sram_ctrl_if
   import mem_stage_sram_ctrl_pkg::*;
#(
   parameter int SRAM_AW = SRAM_AW_DEFAULT
);
   logic [SRAM_AW-1:0] SRAM_ADDR;
   logic [15:0]        SRAM_DQ_out;
   logic               SRAM_DQ_oe;
   logic [15:0]        SRAM_DQ_in;
   logic               SRAM_WE_N;
   logic               SRAM_OE_N;

   modport master (
      output SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N, SRAM_OE_N,
      input  SRAM_DQ_in
   );

   modport slave (
      input  SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N, SRAM_OE_N,
      output SRAM_DQ_in
   );
endinterface

// File: rtl/mem_stage_sram_ctrl_sram_wait_counter.sv
// rtl/mem_stage_sram_ctrl_sram_wait_counter.sv - 0..MAX wait counter with last flag
module sram_wait_counter #(
   parameter int MAX = 1,
   parameter int W   = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count,
   output logic [W-1:0] count_nxt,
   output logic         last
);
   localparam logic [W-1:0] CNT_MAX = W'(MAX);

   assign last = (count == CNT_MAX);

   // count_nxt is exported so the owner can register outputs for the coming cycle
   always_comb begin
      count_nxt = count;
      if (clr)
         count_nxt = '0;
      else if (en)
         count_nxt = last ? '0 : count + W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else
         count <= count_nxt;
   end
endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - MEM-stage 32-bit access over a 16-bit SRAM, two half-word transfers
module mem_stage_sram_ctrl
   import mem_stage_sram_ctrl_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
   parameter int          WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
   parameter int          SRAM_AW     = SRAM_AW_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  MEM_R_En,
   input  logic                  MEM_W_En,
   input  logic [31:0]           ALU_result,
   input  logic [31:0]           ST_val,
   output logic [31:0]           read_data,
   output logic                  ready,
   mem_stage_sram_ctrl_if.master sram
);
   localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_CYCLES);

   mem_state_t         state_q, state_n;
   logic [SRAM_AW-2:0] word_q, word_in, word_s;
   logic [31:0]        data_q, data_s, off;
   logic               wr_q, wr_s, req;
   logic               cnt_clr, cnt_en, cnt_last;
   logic [CW-1:0]      cnt, cnt_nxt;
   logic               active_n, half_n, last_n, xfer_q;

   assign req     = MEM_R_En | MEM_W_En;
   assign off     = ALU_result - BASE_ADDR;
   assign word_in = (SRAM_AW-1)'(off >> 2);

   sram_wait_counter #(.MAX(WAIT_CYCLES), .W(CW)) u_wait (
      .clk       (clk),
      .rst       (rst),
      .clr       (cnt_clr),
      .en        (cnt_en),
      .count     (cnt),
      .count_nxt (cnt_nxt),
      .last      (cnt_last)
   );

   always_comb begin
      state_n = state_q;
      ready   = 1'b1;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ready   = ~req;
            cnt_clr = 1'b1;
            if (req)
               state_n = ST_LO;
         end
         ST_LO: begin
            ready  = 1'b0;
            cnt_en = 1'b1;
            if (cnt_last)
               state_n = ST_HI;
         end
         ST_HI: begin
            ready  = 1'b0;
            cnt_en = 1'b1;
            if (cnt_last)
               state_n = ST_DONE;
         end
         ST_DONE: begin
            cnt_clr = 1'b1;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Pads are registered from the coming cycle's state, so the first LO cycle uses live inputs
   always_comb begin
      word_s   = (state_q == ST_IDLE) ? word_in  : word_q;
      data_s   = (state_q == ST_IDLE) ? ST_val   : data_q;
      wr_s     = (state_q == ST_IDLE) ? MEM_W_En : wr_q;
      active_n = (state_n == ST_LO) || (state_n == ST_HI);
      half_n   = (state_n == ST_HI);
      last_n   = (cnt_nxt == CNT_MAX);
      xfer_q   = (state_q == ST_LO) || (state_q == ST_HI);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         word_q           <= '0;
         data_q           <= '0;
         wr_q             <= 1'b0;
         read_data        <= '0;
         sram.SRAM_ADDR   <= '0;
         sram.SRAM_DQ_out <= '0;
         sram.SRAM_DQ_oe  <= 1'b0;
         sram.SRAM_WE_N   <= 1'b1;
         sram.SRAM_OE_N   <= 1'b1;
      end else begin
         state_q <= state_n;
         if (state_q == ST_IDLE && req) begin
            word_q <= word_in;
            data_q <= ST_val;
            wr_q   <= MEM_W_En;
         end
         if (active_n) begin
            sram.SRAM_ADDR <= {word_s, half_n};
            if (wr_s)
               sram.SRAM_DQ_out <= half_n ? data_s[31:16] : data_s[15:0];
         end
         sram.SRAM_DQ_oe <= active_n & wr_s;
         sram.SRAM_WE_N  <= ~(active_n & wr_s & ~last_n);
         sram.SRAM_OE_N  <= ~(active_n & ~wr_s);
         if (xfer_q && cnt_last && !wr_q) begin
            if (state_q == ST_LO)
               read_data[15:0]  <= sram.SRAM_DQ_in;
            else
               read_data[31:16] <= sram.SRAM_DQ_in;
         end
      end
   end
endmodule
